upload_rr_arbiter: RTL and testbench

Shares the single upload byte path between up to NUM_SRC command handlers (DSM measure, UART, SPI, …). Each handler drives its own upload request, active, data, source and valid signals and receives a ready. The arbiter grants the path round-robin and holds the grant for a whole handler transaction. It forwards bytes, tagged with source, to the packet framer through one registered stage, and a watchdog revokes stalled grants.

---
 rtl/upload_pkg.sv | 18 +
 rtl/upload_rr_arbiter_rr_pick.sv | 35 +++
 rtl/upload_rr_arbiter.sv | 133 +++++++++++++
 tb/tb_upload_rr_arbiter.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/upload_pkg.sv
// Shared definitions for the upload byte path: source tags, default requester
// count and the arbiter state encoding.
package upload_pkg;

    localparam int DEF_NUM_SRC = 4;

    localparam logic [7:0] SRC_DSM  = 8'h0A;
    localparam logic [7:0] SRC_UART = 8'h0B;
    localparam logic [7:0] SRC_SPI  = 8'h0C;
    localparam logic [7:0] SRC_CMD  = 8'h0D;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_RELEASE = 2'd2
    } arb_state_e;

endpackage

// File: rtl/upload_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester found scanning upward from
// last_grant+1, wrapping modulo NUM_SRC.
module rr_pick
    import upload_pkg::*;
#(
    parameter int NUM_SRC = DEF_NUM_SRC
) (
    input  logic [NUM_SRC-1:0]         req,
    input  logic [$clog2(NUM_SRC)-1:0] last_grant,
    output logic [$clog2(NUM_SRC)-1:0] winner,
    output logic                       any_req
);

    localparam int GW = $clog2(NUM_SRC);

    logic [GW-1:0] idx;
    logic          found;

    // Offset 1 first so the previous winner is considered last.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = '0;
        for (int i = 1; i <= NUM_SRC; i++) begin
            idx = GW'((int'(last_grant) + i) % NUM_SRC);
            if (!found && req[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    assign any_req = |req;

endmodule

// File: rtl/upload_rr_arbiter.sv
// Round-robin owner of the shared upload byte path: grants one handler per
// transaction, forwards its bytes through one register, revokes stalled grants.
module upload_rr_arbiter
    import upload_pkg::*;
#(
    parameter int NUM_SRC = DEF_NUM_SRC,
    parameter int TIMEOUT = 4096
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_SRC-1:0]         src_req,
    input  logic [NUM_SRC-1:0]         src_active,
    input  logic [NUM_SRC*8-1:0]       src_data,
    input  logic [NUM_SRC*8-1:0]       src_source,
    input  logic [NUM_SRC-1:0]         src_valid,
    output logic [NUM_SRC-1:0]         src_ready,
    output logic [7:0]                 up_data,
    output logic [7:0]                 up_source,
    output logic                       up_valid,
    input  logic                       up_ready,
    output logic [$clog2(NUM_SRC)-1:0] grant_id,
    output logic                       busy,
    output logic                       timeout_err
);

    localparam int              GW      = $clog2(NUM_SRC);
    localparam int              WD_W    = $clog2(TIMEOUT);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    arb_state_e      state;
    logic [GW-1:0]   last_grant;
    logic [WD_W-1:0] wdog;
    logic [GW-1:0]   winner;
    logic            any_req;

    logic [7:0]      data_p1;
    logic [7:0]      source_p1;
    logic            vld_p1;

    logic [7:0]      data_arr   [NUM_SRC];
    logic [7:0]      source_arr [NUM_SRC];
    logic            g_valid;
    logic            g_release;

    function automatic logic [WD_W-1:0] wdog_inc(input logic [WD_W-1:0] v);
        return (v == WD_LAST) ? v : v + WD_W'(1);
    endfunction

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_slot
        assign data_arr[i]   = src_data[8*i +: 8];
        assign source_arr[i] = src_source[8*i +: 8];
    end

    rr_pick #(
        .NUM_SRC    (NUM_SRC)
    ) u_pick (
        .req        (src_req),
        .last_grant (last_grant),
        .winner     (winner),
        .any_req    (any_req)
    );

    assign g_valid   = src_valid[grant_id];
    assign g_release = !src_req[grant_id] && !src_active[grant_id];

    // Ready depends only on registered grant state and up_ready, never on src_valid.
    always_comb begin
        src_ready = '0;
        if (state == ST_GRANT) begin
            src_ready[grant_id] = up_ready;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            grant_id    <= '0;
            last_grant  <= GW'(NUM_SRC - 1);
            wdog        <= '0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
            data_p1     <= '0;
            source_p1   <= '0;
            vld_p1      <= 1'b0;
        end else begin
            vld_p1      <= 1'b0;
            timeout_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        state      <= ST_GRANT;
                        grant_id   <= winner;
                        last_grant <= winner;
                        wdog       <= '0;
                        busy       <= 1'b1;
                    end
                end
                ST_GRANT: begin
                    // p0 -> p1: capture the granted slot's byte, including on the release cycle
                    if (g_valid) begin
                        vld_p1    <= 1'b1;
                        data_p1   <= data_arr[grant_id];
                        source_p1 <= source_arr[grant_id];
                    end
                    if (g_release) begin
                        state <= ST_RELEASE;
                        busy  <= 1'b0;
                    end else if (g_valid) begin
                        wdog <= '0;
                    end else if (wdog == WD_LAST) begin
                        state       <= ST_RELEASE;
                        busy        <= 1'b0;
                        timeout_err <= 1'b1;
                    end else begin
                        wdog <= wdog_inc(wdog);
                    end
                end
                ST_RELEASE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign up_data   = data_p1;
    assign up_source = source_p1;
    assign up_valid  = vld_p1;

endmodule

// File: tb/tb_upload_rr_arbiter.sv
// Directed bench for upload_rr_arbiter: a default instance plus a TIMEOUT=16
// instance for the watchdog cases.
module tb_upload_rr_arbiter;
    import upload_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req, active, valid;
    logic [31:0] data, source;
    logic        up_ready;
    logic [3:0]  src_ready;
    logic [7:0]  up_data, up_source;
    logic        up_valid;
    logic [1:0]  grant_id;
    logic        busy, timeout_err;

    logic [3:0]  w_req, w_active, w_valid;
    logic        w_up_ready;
    logic [3:0]  w_src_ready;
    logic [7:0]  w_up_data, w_up_source;
    logic        w_up_valid;
    logic [1:0]  w_grant_id;
    logic        w_busy, w_timeout_err;

    int n_vec, n_err;
    int prev_g;

    upload_rr_arbiter #(.NUM_SRC(4), .TIMEOUT(4096)) dut (
        .clk(clk), .rst_n(rst_n), .src_req(req), .src_active(active),
        .src_data(data), .src_source(source), .src_valid(valid),
        .src_ready(src_ready), .up_data(up_data), .up_source(up_source),
        .up_valid(up_valid), .up_ready(up_ready), .grant_id(grant_id),
        .busy(busy), .timeout_err(timeout_err)
    );

    upload_rr_arbiter #(.NUM_SRC(4), .TIMEOUT(16)) dut_wd (
        .clk(clk), .rst_n(rst_n), .src_req(w_req), .src_active(w_active),
        .src_data(data), .src_source(source), .src_valid(w_valid),
        .src_ready(w_src_ready), .up_data(w_up_data), .up_source(w_up_source),
        .up_valid(w_up_valid), .up_ready(w_up_ready), .grant_id(w_grant_id),
        .busy(w_busy), .timeout_err(w_timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_time_limit: got running expected finished");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic reset_pulse();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    // Drives the watchdog instance for revoke_at cycles; optional valid at valid_at.
    task automatic wd_run(input int revoke_at, input int valid_at, input int src);
        for (int k = 1; k <= revoke_at; k++) begin
            w_valid = (k == valid_at) ? (4'b0001 << src) : 4'b0000;
            tick();
            if (k == valid_at) begin
                chk_eq("wd_fwd_vld", w_up_valid, 1);
                chk_eq("wd_fwd_data", w_up_data, 8'h3C);
                chk_eq("wd_fwd_src", w_up_source, 8'h0D);
            end
            if (k < revoke_at) begin
                chk_eq("wd_busy_hold", w_busy, 1);
                chk_eq("wd_no_timeout", w_timeout_err, 0);
            end else begin
                chk_eq("wd_timeout_pulse", w_timeout_err, 1);
                chk_eq("wd_busy_drop", w_busy, 0);
            end
        end
        w_valid = 4'b0000;
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        rst_n = 1'b0; req = '0; active = '0; valid = '0; data = '0; up_ready = 1'b1;
        w_req = '0; w_active = '0; w_valid = '0; w_up_ready = 1'b1;
        source = {SRC_CMD, SRC_SPI, SRC_UART, SRC_DSM};
        tick(); tick();

        chk_eq("rst_src_ready", src_ready, 0);
        chk_eq("rst_up_data", up_data, 0);
        chk_eq("rst_up_source", up_source, 0);
        chk_eq("rst_up_valid", up_valid, 0);
        chk_eq("rst_grant_id", grant_id, 0);
        chk_eq("rst_busy", busy, 0);
        chk_eq("rst_timeout", timeout_err, 0);
        chk_eq("rst_wd_busy", w_busy, 0);
        rst_n = 1'b1;

        // Single source 0, nine bytes, req dropping between bytes while active holds
        req[0] = 1'b1; active[0] = 1'b1;
        tick();
        chk_eq("t1_busy", busy, 1);
        chk_eq("t1_grant", grant_id, 0);
        chk_eq("t1_ready", src_ready, 4'b0001);
        for (int b = 0; b < 9; b++) begin
            req[0] = 1'b1; valid[0] = 1'b1; data[7:0] = 8'(b);
            tick();
            chk_eq("t1_vld", up_valid, 1);
            chk_eq("t1_data", up_data, 8'(b));
            chk_eq("t1_tag", up_source, 8'h0A);
            req[0] = 1'b0; valid[0] = 1'b0;
            tick();
            chk_eq("t1_gap_vld", up_valid, 0);
            chk_eq("t1_gap_busy", busy, 1);
            chk_eq("t1_gap_hold", up_data, 8'(b));
        end
        active[0] = 1'b0;
        tick();
        chk_eq("t1_release", busy, 0);
        tick(); tick();

        // Sources 1 and 2 together from reset
        reset_pulse();
        req = 4'b0110; active = 4'b0110;
        tick();
        chk_eq("t2_first_grant", grant_id, 1);
        chk_eq("t2_busy", busy, 1);
        chk_eq("t2_ready", src_ready, 4'b0010);
        valid = 4'b0110; data[15:8] = 8'h51; data[23:16] = 8'h62;
        tick();
        chk_eq("t2_vld", up_valid, 1);
        chk_eq("t2_data_nongrant_dropped", up_data, 8'h51);
        chk_eq("t2_tag", up_source, 8'h0B);
        valid = 4'b0010; data[15:8] = 8'h52; req[1] = 1'b0; active[1] = 1'b0;
        tick();
        chk_eq("t2_rel_busy", busy, 0);
        chk_eq("t2_rel_fwd_vld", up_valid, 1);
        chk_eq("t2_rel_fwd_data", up_data, 8'h52);
        data[15:8] = 8'h53;
        tick();
        chk_eq("t2_gap_busy", busy, 0);
        chk_eq("t2_late_dropped", up_valid, 0);
        chk_eq("t2_late_hold", up_data, 8'h52);
        valid = 4'b0000;
        tick();
        chk_eq("t2_second_busy", busy, 1);
        chk_eq("t2_second_grant", grant_id, 2);
        chk_eq("t2_second_ready", src_ready, 4'b0100);
        req = 4'b0000; active = 4'b0000;
        tick(); tick(); tick();

        // All four sources, 3-byte transactions, continuous re-request
        reset_pulse();
        req = 4'b1111; active = 4'b1111;
        tick();
        prev_g = 4;
        for (int t = 0; t < 5; t++) begin
            chk_eq("t3_grant_order", grant_id, 32'(t % 4));
            chk_eq("t3_busy", busy, 1);
            chk_eq("t3_no_repeat", (32'(grant_id) == prev_g), 0);
            prev_g = t % 4;
            if (t < 4) begin
                for (int b = 0; b < 3; b++) begin
                    valid = 4'b0001 << (t % 4);
                    data[8*(t%4) +: 8] = 8'((t % 4) * 16 + b);
                    if (b == 2) begin
                        req[t%4] = 1'b0; active[t%4] = 1'b0;
                    end
                    tick();
                    chk_eq("t3_vld", up_valid, 1);
                    chk_eq("t3_data", up_data, 32'((t % 4) * 16 + b));
                    chk_eq("t3_tag", up_source, 32'(source[8*(t%4) +: 8]));
                end
                valid = 4'b0000; req[t%4] = 1'b1; active[t%4] = 1'b1;
                chk_eq("t3_rel_busy", busy, 0);
                tick();
                chk_eq("t3_idle_busy", busy, 0);
                tick();
            end
        end

        // Source 0 holds grant while downstream stalls for 20 cycles
        req = 4'b0001; active = 4'b0001;
        up_ready = 1'b0;
        #1;
        chk_eq("t4_ready_low", src_ready, 0);
        for (int c = 0; c < 20; c++) begin
            tick();
            chk_eq("t4_stall_ready", src_ready, 0);
            chk_eq("t4_stall_vld", up_valid, 0);
            chk_eq("t4_stall_busy", busy, 1);
        end
        up_ready = 1'b1;
        #1;
        chk_eq("t4_ready_back", src_ready, 4'b0001);
        valid[0] = 1'b1; data[7:0] = 8'hA5;
        tick();
        chk_eq("t4_resume_vld", up_valid, 1);
        chk_eq("t4_resume_data", up_data, 8'hA5);
        valid = 4'b0000; req = 4'b0000; active = 4'b0000;
        tick();
        chk_eq("t4_release", busy, 0);
        tick(); tick();

        // Watchdog on the TIMEOUT=16 instance
        w_req = 4'b0010; w_active = 4'b0010;
        tick();
        chk_eq("wd_grant1", w_grant_id, 1);
        chk_eq("wd_ready1", w_src_ready, 4'b0010);
        w_req = 4'b1000; w_active = 4'b1010;
        wd_run(16, 0, 1);
        tick();
        chk_eq("wd_pulse_end", w_timeout_err, 0);
        chk_eq("wd_gap_busy", w_busy, 0);
        tick();
        chk_eq("wd_pending_busy", w_busy, 1);
        chk_eq("wd_pending_grant", w_grant_id, 3);
        w_req = 4'b0000; w_active = 4'b1000; data[31:24] = 8'h3C;
        wd_run(26, 10, 3);
        w_active = 4'b0000;
        tick(); tick();

        // Reset during byte 4 of a source-1 transaction
        req = 4'b0010; active = 4'b0010;
        tick();
        chk_eq("t6_grant", grant_id, 1);
        for (int b = 0; b < 4; b++) begin
            valid = 4'b0010; data[15:8] = 8'(8'h40 + b);
            tick();
            chk_eq("t6_data", up_data, 32'(8'h40 + b));
        end
        valid = 4'b0010; data[15:8] = 8'h44;
        #2;
        rst_n = 1'b0;
        #1;
        chk_eq("t6_rst_busy", busy, 0);
        chk_eq("t6_rst_grant", grant_id, 0);
        chk_eq("t6_rst_vld", up_valid, 0);
        chk_eq("t6_rst_data", up_data, 0);
        chk_eq("t6_rst_tag", up_source, 0);
        chk_eq("t6_rst_ready", src_ready, 0);
        chk_eq("t6_rst_timeout", timeout_err, 0);
        valid = 4'b0000; req = 4'b0101; active = 4'b0101;
        tick();
        rst_n = 1'b1;
        tick();
        chk_eq("t6_after_busy", busy, 1);
        chk_eq("t6_after_grant", grant_id, 0);
        chk_eq("t6_after_ready", src_ready, 4'b0001);
        req[0] = 1'b0; active[0] = 1'b0;
        tick(); tick(); tick();
        chk_eq("t6_next_grant", grant_id, 2);
        chk_eq("t6_next_busy", busy, 1);
        req = 4'b0000; active = 4'b0000;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
